expr_eval: RTL and testbench

EXPR_EVAL -- requirements
Module: expr_eval

---
 rtl/expr_eval.sv | 147 ++++++++++++++
 tb/tb_expr_eval.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
//  Module      : expr_eval
//  Description : Streaming evaluator for single-digit ASCII expressions of the
//                form d ( op d )*, op in {'+','*'}, with '*' binding tighter
//                than '+'. One character is consumed per valid cycle; all
//                arithmetic wraps modulo 2^W.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic [W-1:0] result,
    output logic         ok,
    output logic         err
);

    localparam logic [7:0] c_CH_0    = 8'h30;
    localparam logic [7:0] c_CH_9    = 8'h39;
    localparam logic [7:0] c_CH_PLUS = 8'h2B;
    localparam logic [7:0] c_CH_STAR = 8'h2A;

    typedef enum logic [2:0] {
        EXP_FIRST = 3'd0,
        GOT_NUM   = 3'd1,
        GOT_ADD   = 3'd2,
        GOT_MUL   = 3'd3,
        ERR       = 3'd4
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_sum;
    logic [W-1:0]   r_term;
    logic [W-1:0]   r_result;
    logic           r_ok;
    logic           r_err;

    logic           w_is_digit;
    logic           w_is_plus;
    logic           w_is_star;
    logic [W-1:0]   w_dval;
    logic [W-1:0]   w_prod;
    logic [W-1:0]   w_add_res;
    logic [W-1:0]   w_mul_res;

    // Character classification. For ASCII '0'..'9' the low nibble is the
    // digit value, so no subtraction is needed.
    assign w_is_digit = (in >= c_CH_0) && (in <= c_CH_9);
    assign w_is_plus  = (in == c_CH_PLUS);
    assign w_is_star  = (in == c_CH_STAR);
    assign w_dval     = W'(in[3:0]);

    // Candidate term/result values for the two ways of reaching GOT_NUM
    // after the first operand.
    assign w_prod     = r_term * w_dval;
    assign w_add_res  = r_sum + w_dval;
    assign w_mul_res  = r_sum + w_prod;

    // Parser FSM with registered datapath and flags; ERR freezes everything.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= EXP_FIRST;
            r_sum    <= '0;
            r_term   <= '0;
            r_result <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else if (start) begin
            r_state  <= EXP_FIRST;
            r_sum    <= '0;
            r_term   <= '0;
            r_result <= '0;
            r_ok     <= 1'b0;
            r_err    <= 1'b0;
        end else if (in_valid) begin
            case (r_state)
                EXP_FIRST: begin
                    if (w_is_digit) begin
                        r_state  <= GOT_NUM;
                        r_sum    <= '0;
                        r_term   <= w_dval;
                        r_result <= w_dval;
                        r_ok     <= 1'b1;
                    end else begin
                        r_state  <= ERR;
                        r_ok     <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                GOT_NUM: begin
                    if (w_is_plus) begin
                        r_state  <= GOT_ADD;
                        r_sum    <= r_sum + r_term;
                        r_ok     <= 1'b0;
                    end else if (w_is_star) begin
                        r_state  <= GOT_MUL;
                        r_ok     <= 1'b0;
                    end else begin
                        r_state  <= ERR;
                        r_ok     <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                GOT_ADD: begin
                    if (w_is_digit) begin
                        r_state  <= GOT_NUM;
                        r_term   <= w_dval;
                        r_result <= w_add_res;
                        r_ok     <= 1'b1;
                    end else begin
                        r_state  <= ERR;
                        r_ok     <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                GOT_MUL: begin
                    if (w_is_digit) begin
                        r_state  <= GOT_NUM;
                        r_term   <= w_prod;
                        r_result <= w_mul_res;
                        r_ok     <= 1'b1;
                    end else begin
                        r_state  <= ERR;
                        r_ok     <= 1'b0;
                        r_err    <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ERR;
                    r_ok     <= 1'b0;
                    r_err    <= 1'b1;
                end
            endcase
        end
    end

    assign result = r_result;
    assign ok     = r_ok;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_eval
//  Description : Self-checking bench for expr_eval. A behavioural model
//                predicts outputs per applied character; predictions are
//                queued on drive and compared after the consuming edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_eval;

    localparam int W    = 16;
    localparam int MASK = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ok;
        logic         err;
    } exp_t;

    logic         clk;
    logic         clr;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_c;
    logic [W-1:0] result;
    logic         ok;
    logic         err;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // model state: 0 EXP_FIRST, 1 GOT_NUM, 2 GOT_ADD, 3 GOT_MUL, 4 ERR
    int m_st   = 0;
    int m_sum  = 0;
    int m_term = 0;
    int m_res  = 0;

    expr_eval #(.W(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .in_valid (in_valid),
        .in       (in_c),
        .result   (result),
        .ok       (ok),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sum = 0; m_term = 0; m_res = 0;
    endtask

    task automatic model_step(input logic [7:0] ch);
        bit is_d;
        int d;
        is_d = (ch >= 8'h30) && (ch <= 8'h39);
        d    = int'(ch) - 48;
        case (m_st)
            0: if (is_d) begin m_term = d; m_sum = 0; m_res = d; m_st = 1; end
               else m_st = 4;
            1: if (ch == "+") begin m_sum = (m_sum + m_term) & MASK; m_st = 2; end
               else if (ch == "*") m_st = 3;
               else m_st = 4;
            2: if (is_d) begin m_term = d; m_res = (m_sum + d) & MASK; m_st = 1; end
               else m_st = 4;
            3: if (is_d) begin
                   m_term = (m_term * d) & MASK;
                   m_res  = (m_sum + m_term) & MASK;
                   m_st   = 1;
               end else m_st = 4;
            default: m_st = 4;
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.res = m_res[W-1:0];
        e.ok  = (m_st == 1);
        e.err = (m_st == 4);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk_val({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val({tag, "_result"}, result, e.res);
            chk_val({tag, "_ok"},     ok,     e.ok);
            chk_val({tag, "_err"},    err,    e.err);
        end
    endtask

    // one cycle of stimulus: drive at negedge, compare #1 after posedge
    task automatic drive(input logic [7:0] ch, input logic v, input logic st);
        @(negedge clk);
        in_c = ch; in_valid = v; start = st;
        if (st) model_reset();
        else if (v) model_step(ch);
        push_exp();
        @(posedge clk);
        #1;
        pop_cmp(st ? "start" : (v ? "char" : "idle"));
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
    endtask

    task automatic restart();
        drive(8'h00, 1'b0, 1'b1);
    endtask

    // asynchronous clear pulse placed between clock edges
    task automatic clr_pulse(input string tag);
        @(negedge clk);
        #1 clr = 1'b0;
        #1;
        model_reset();
        chk_val({tag, "_result"}, result, 0);
        chk_val({tag, "_ok"},     ok,     0);
        chk_val({tag, "_err"},    err,    0);
        #1 clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; in_valid = 1'b0; in_c = 8'h00;
        #2;
        chk_val("por_result", result, 0);
        chk_val("por_ok",     ok,     0);
        chk_val("por_err",    err,    0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;

        // "1+2*3": ok pattern 1,0,1,0,1 comes out of the scoreboard
        send_str("1+2*3");
        chk_val("e1_result", result, 7);
        chk_val("e1_ok",     ok,     1);

        // async clear with no edge
        clr_pulse("clr_async");

        send_str("2*3+4*5");
        chk_val("e2_result", result, 26);
        chk_val("e2_ok",     ok,     1);

        restart();
        send_str("1+");
        chk_val("e3_result", result, 1);
        chk_val("e3_ok",     ok,     0);
        chk_val("e3_err",    err,    0);

        restart();
        send_str("12");
        chk_val("e4_result", result, 1);
        chk_val("e4_ok",     ok,     0);
        chk_val("e4_err",    err,    1);

        restart();
        send_str("a5+");
        chk_val("e5_result", result, 0);
        chk_val("e5_err",    err,    1);

        restart();
        send_str("9*9*9*9*9*9");
        chk_val("e6_result", result, 7153);

        // in_valid gaps carrying junk that must be ignored
        restart();
        drive("3", 1'b1, 1'b0);
        drive("9", 1'b0, 1'b0);
        drive("*", 1'b1, 1'b0);
        drive("+", 1'b0, 1'b0);
        drive("7", 1'b0, 1'b0);
        drive("4", 1'b1, 1'b0);
        chk_val("e7_result", result, 12);

        // start wins over a valid '5'
        drive("5", 1'b1, 1'b1);
        chk_val("e8_result", result, 0);
        chk_val("e8_ok",     ok,     0);
        send_str("7");
        chk_val("e8b_result", result, 7);
        chk_val("e8b_ok",     ok,     1);

        // clear between '*' and the next digit discards the partial product
        restart();
        send_str("2*");
        clr_pulse("clr_mid");
        send_str("4");
        chk_val("e9_result", result, 4);
        chk_val("e9_ok",     ok,     1);
        chk_val("e9_err",    err,    0);

        chk_val("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
